// File: rtl/shift_frame_pkg.sv
// shift_frame_pkg: frame constants, FSM state type and frame builder for shift_frame_transmitter
package shift_frame_pkg;
  localparam int FRAME_BITS = 11;
  localparam int CNT_W = 4;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, GUARD} state_t;
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data, input logic par);
    return {START_BIT, par, data, STOP_BIT};
  endfunction
endpackage

// File: rtl/shift_frame_transmitter_if.sv
// shift_frame_transmitter_if: producer handshake and serial-line bundle
interface shift_frame_transmitter_if;
  logic [7:0] PARALLEL_DATA_INPUT;
  logic TX_VALID;
  logic TX_READY;
  logic SERIAL_DATA_OUTPUT;
  logic BUSY;
  logic FRAME_DONE;
  modport master(output PARALLEL_DATA_INPUT, TX_VALID, input TX_READY, SERIAL_DATA_OUTPUT, BUSY, FRAME_DONE);
  modport slave(input PARALLEL_DATA_INPUT, TX_VALID, output TX_READY, SERIAL_DATA_OUTPUT, BUSY, FRAME_DONE);
endinterface

// File: rtl/shift_frame_transmitter_tx_holding_buffer.sv
// tx_holding_buffer: one-deep byte register, accepts on valid&&ready, freed by load
module tx_holding_buffer (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       load,
  output logic [7:0] out_data,
  output logic       empty
);
  logic full_q, full_d;
  logic [7:0] data_q, data_d;
  always_comb begin
    full_d = (in_valid && !full_q) || (full_q && !load);
    data_d = in_valid && !full_q ? in_data : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end
  assign in_ready = !full_q;
  assign empty = !full_q;
  assign out_data = data_q;
endmodule

// File: rtl/shift_frame_transmitter.sv
// shift_frame_transmitter: 8-bit to 11-bit MSB-first serial framer; SHIFT_TX_PARITY_EN enables odd parity
module shift_frame_transmitter
  import shift_frame_pkg::*;
#(
  parameter int GUARD_CYCLES = 1
) (
  input logic CONTROL_CLOCK,
  input logic RESET,
  shift_frame_transmitter_if.slave tx
);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [2:0] LAST_GUARD = 3'(GUARD_CYCLES > 0 ? GUARD_CYCLES - 1 : 0);
  logic [7:0] buf_data;
  logic buf_empty, launch, frame_end, par;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] gcnt_q, gcnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic busy_q, busy_d, done_q, done_d;
  tx_holding_buffer u_buf (
    .clk(CONTROL_CLOCK),
    .rst(RESET),
    .in_data(tx.PARALLEL_DATA_INPUT),
    .in_valid(tx.TX_VALID),
    .in_ready(tx.TX_READY),
    .load(launch),
    .out_data(buf_data),
    .empty(buf_empty)
  );
`ifdef SHIFT_TX_PARITY_EN
  assign par = ~^buf_data;
`else
  assign par = 1'b1;
`endif
  // frame register refills with idle level, so its MSB is the line in every state
  always_comb begin
    frame_end = state_q == GUARD ? gcnt_q == LAST_GUARD
              : state_q == SHIFT && cnt_q == LAST_BIT && GUARD_CYCLES == 0;
    launch = !buf_empty && (state_q == IDLE || frame_end);
    state_d = launch ? SHIFT : frame_end ? IDLE : state_q == SHIFT && cnt_q == LAST_BIT ? GUARD : state_q;
    cnt_d = state_q == SHIFT && state_d == SHIFT && !launch ? cnt_q + 1'b1 : '0;
    gcnt_d = state_q == GUARD && state_d == GUARD ? gcnt_q + 1'b1 : '0;
    frame_d = launch ? build_frame(buf_data, par) : {frame_q[FRAME_BITS-2:0], IDLE_LEVEL};
    busy_d = state_d != IDLE;
    done_d = state_d == GUARD ? gcnt_d == LAST_GUARD
           : state_d == SHIFT && cnt_d == LAST_BIT && GUARD_CYCLES == 0;
  end
  always_ff @(posedge CONTROL_CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gcnt_q <= '0;
      frame_q <= '1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gcnt_q <= gcnt_d;
      frame_q <= frame_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign tx.SERIAL_DATA_OUTPUT = frame_q[FRAME_BITS-1];
  assign tx.BUSY = busy_q;
  assign tx.FRAME_DONE = done_q;
endmodule

// File: tb/tb_shift_frame_transmitter.sv
// tb_shift_frame_transmitter: random scoreboard bench with loopback receiver for shift_frame_transmitter
module tb_shift_frame_transmitter;
  parameter int G = 1;
  localparam int S = 11 + G;
`ifdef SHIFT_TX_PARITY_EN
  localparam logic [7:0] KB = 8'hA4;
  localparam logic [10:0] KW = 11'b00101001001;
`else
  localparam logic [7:0] KB = 8'hA5;
  localparam logic [10:0] KW = 11'b01101001011;
`endif
  typedef struct {logic [10:0] w; int s;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0, checks = 0, errors = 0, starts = 0, frames = 0, prev_start = -100;
  int cur_start = -1, done_at = -1, last_start = -1, prev_mon_start = -1, m_n = 0;
  logic m_active = 1'b0, m_have = 1'b0;
  logic [10:0] m_word = '0, last_word = '0;
  exp_t m_cur;
  exp_t q[$];
  shift_frame_transmitter_if tx();
  shift_frame_transmitter #(.GUARD_CYCLES(G)) dut (.CONTROL_CLOCK(clk), .RESET(rst), .tx(tx));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic logic [10:0] exp_word(input logic [7:0] d);
    logic [10:0] w;
    logic p;
`ifdef SHIFT_TX_PARITY_EN
    p = ($countones(d) % 2) == 0;
`else
    p = 1'b1;
`endif
    w = '0;
    w = {w[9:0], 1'b0};
    w = {w[9:0], p};
    for (int i = 7; i >= 0; i--) w = {w[9:0], d[i]};
    w = {w[9:0], 1'b1};
    return w;
  endfunction
  task automatic idle(input int n);
    tx.TX_VALID = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b, output int s);
    exp_t e;
    int n = 0;
    s = -1;
    while (!tx.TX_READY && n < 200) begin
      tx.TX_VALID = 1'b1;
      tx.PARALLEL_DATA_INPUT = 8'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    if (!tx.TX_READY) begin
      chk("send_ready_timeout", tx.TX_READY, 1);
      return;
    end
    tx.TX_VALID = 1'b1;
    tx.PARALLEL_DATA_INPUT = b;
    s = cyc + 2 > prev_start + S ? cyc + 2 : prev_start + S;
    prev_start = s;
    e.w = exp_word(b);
    e.s = s;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (frames < target) chk("frame_timeout", frames, target);
  endtask
  task automatic drain();
    int n = 0;
    tx.TX_VALID = 1'b0;
    while ((q.size() != 0 || m_active) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0 || m_active) chk("drain_timeout", q.size(), 0);
    idle(G + 2);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 1'b0;
        cur_start = -1;
        done_at = -1;
      end else begin
        if (!m_active && !tx.SERIAL_DATA_OUTPUT) begin
          starts++;
          m_active = 1'b1;
          m_n = 0;
          m_word = '0;
          cur_start = cyc;
          done_at = cyc + 10 + G;
          prev_mon_start = last_start;
          last_start = cyc;
          m_have = q.size() != 0;
          if (m_have) begin
            m_cur = q.pop_front();
            chk("start_cycle", cyc, m_cur.s);
          end else chk("unexpected_start", q.size(), 1);
        end
        if (m_active) begin
          m_word = {m_word[9:0], tx.SERIAL_DATA_OUTPUT};
          m_n++;
          if (m_n == 11) begin
            m_active = 1'b0;
            frames++;
            last_word = m_word;
            if (m_have) chk("frame_word", m_word, m_cur.w);
          end
        end
        chk("busy", tx.BUSY, cur_start >= 0 && cyc >= cur_start && cyc <= done_at);
        if (tx.FRAME_DONE || cyc == done_at) chk("frame_done", tx.FRAME_DONE, cyc == done_at);
      end
    end
  end
  initial begin
    int s1, s2, f0, st, n;
    tx.TX_VALID = 1'b0;
    tx.PARALLEL_DATA_INPUT = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_done", tx.FRAME_DONE, 0);
    repeat (20) begin
      chk("idle_line", tx.SERIAL_DATA_OUTPUT, 1);
      chk("idle_ready", tx.TX_READY, 1);
      chk("idle_busy", tx.BUSY, 0);
      @(posedge clk);
      #1;
    end
    f0 = frames;
    send(KB, s1);
    tx.TX_VALID = 1'b0;
    wait_frames(f0 + 1);
    chk("known_pattern", last_word, KW);
    idle(5);
    f0 = frames;
    send(8'h00, s1);
    send(8'hFF, s2);
    tx.TX_VALID = 1'b0;
    wait_frames(f0 + 2);
    chk("b2b_gap", last_start - prev_mon_start, S);
    idle(5);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 15));
      send(8'($urandom), s1);
    end
    drain();
    send(8'h3C, s1);
    send(8'hC3, s2);
    tx.TX_VALID = 1'b0;
    n = 0;
    while (cyc < s1 + 5 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    q.delete();
    prev_start = -100;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_line", tx.SERIAL_DATA_OUTPUT, 1);
    chk("rst_ready", tx.TX_READY, 1);
    chk("rst_busy", tx.BUSY, 0);
    chk("rst_done", tx.FRAME_DONE, 0);
    st = starts;
    idle(30);
    chk("no_restart", starts, st);
    f0 = frames;
    send(8'h5A, s1);
    tx.TX_VALID = 1'b0;
    wait_frames(f0 + 1);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_frame_transmitter.md
# shift_frame_transmitter

Serializes 8-bit parallel bytes into 11-bit frames on a single serial line, one bit per CONTROL_CLOCK cycle, for the downstream 11-bit shift-register receiver. Sits between the byte producer (valid/ready handshake) and the serial link. It owns the frame format, parity generation, inter-frame guard time and a one-deep holding buffer, so the producer can queue the next byte while the current frame shifts out.

## Interface
- GUARD_CYCLES, 1, idle-high cycles appended after each stop bit (legal 0..4); the default gives the 12-cycle frame slot the receiver counts.
- CONTROL_CLOCK  input  1  sole clock, rising edge.
- RESET  input  1  synchronous, active-high.
- PARALLEL_DATA_INPUT  input  8  byte to send, sampled when TX_VALID && TX_READY.
- TX_VALID  input  1  producer has a byte.
- TX_READY  output  1  holding buffer empty; may take a byte this cycle.
- SERIAL_DATA_OUTPUT  output  1  registered serial line, idle high.
- BUSY  output  1  high while a frame or guard period is in progress.
- FRAME_DONE  output  1  one-cycle pulse in the last guard cycle; in the stop-bit cycle when GUARD_CYCLES=0.

## Operation
- Frame order, first to last: start (0), parity, D7, D6 … D0, stop (1). This is MSB-first, and it puts data at receiver bits [8:1] and parity at [9].
- Parity bit = ~^data (odd parity) when the macro is enabled. See Configuration.
- FSM states: IDLE, SHIFT, GUARD.
  - IDLE → SHIFT when the holding buffer is full. The buffer is loaded into an 11-bit frame shift register and the buffer is freed in the same edge.
  - SHIFT: a 4-bit bit counter runs 0..10. Output = frame register MSB, and the register shifts left each cycle. At count 10 the FSM goes to GUARD, or to the next state per the GUARD_CYCLES=0 rule.
  - GUARD: the line is held at 1 for GUARD_CYCLES cycles. At the end the FSM goes to SHIFT if the buffer is full (back-to-back, no extra gap), otherwise to IDLE.
- With GUARD_CYCLES=0, the stop-bit cycle behaves as the last guard cycle.
- Holding buffer: TX_READY = buffer empty. A byte accepted while a frame is shifting waits in the buffer.
- Simultaneous buffer load and frame launch on the same edge:
  - Legal only when the buffer is empty at that edge.
  - The new byte goes to the buffer.
  - TX_VALID while TX_READY is low is ignored, with no overwrite.
- Reset mid-frame: the frame is aborted and the buffer content is discarded.
- After reset:
  - SERIAL_DATA_OUTPUT=1, TX_READY=1, BUSY=0, FRAME_DONE=0.
  - Counters are 0, state is IDLE.

## Timing
- Accept at edge N while IDLE → buffer is full after N. Frame loaded at N+1. Start bit is on SERIAL_DATA_OUTPUT after edge N+1.
- Latency from handshake to start bit: 2 cycles.
- Frame slot = 11 + GUARD_CYCLES cycles (12 by default). Stop bit is visible in slot cycle 10.
- TX_READY goes high the cycle after the buffer is loaded into the frame register.
- BUSY is high from the start-bit cycle through the last guard cycle.
- Sustained throughput with TX_VALID held high: one byte per 11+GUARD_CYCLES cycles, with zero-gap start bits.

## Configuration
- SHIFT_TX_PARITY_EN
  - Defined: the parity slot carries odd parity of the data byte.
  - Undefined: the parity slot is driven constant 1. Frame length and bit positions are unchanged, so receiver alignment holds.

## Structure
- Package shift_frame_pkg holds:
  - FRAME_BITS=11, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1;
  - the FSM state typedef (IDLE, SHIFT, GUARD);
  - the bit-counter width constant.
- One sub-module: tx_holding_buffer, a one-deep byte register with valid/ready in and load/empty out.
- Frame assembly, FSM and counters live in the top module.

## Test plan
- Reset then idle: hold RESET 3 cycles, TX_VALID=0 for 20 cycles → SERIAL_DATA_OUTPUT=1, TX_READY=1, BUSY=0 throughout.
- Single byte 0xA4 with parity enabled: accepted at cycle 0 → from cycle 2, line = 0,0,1,0,1,0,0,1,0,0,1, then 1 guard cycle. FRAME_DONE pulses in cycle 13. A loopback receiver reports data 0xA4, parity 0.
- Single byte 0xA5 without SHIFT_TX_PARITY_EN → line = 0,1,1,0,1,0,0,1,0,1,1, and the parity slot is 1.
- Back-to-back 0x00 then 0xFF, TX_VALID held high:
  - the second byte is accepted while the first shifts;
  - start bits are exactly 12 cycles apart;
  - TX_VALID held across the full buffer does not corrupt the queued byte.
- Reset asserted at frame bit 5 with a byte buffered → the line returns to 1 the next cycle, TX_READY=1, and no further start bit appears.
- GUARD_CYCLES=0 and GUARD_CYCLES=4 builds → frame periods are 11 and 15 cycles, and FRAME_DONE pulses in the stop-bit cycle and the 4th guard cycle respectively.
